// File: rtl/capture_reader_if.sv
// capture_reader_if
//   Bundles the two data paths of the capture read-back engine:
//   - Wishbone read-only bus towards port B of the sample RAM
//     mem_addr_o[31:0], mem_sel_o[3:0], mem_we_o, mem_stb_o  (master -> slave)
//     mem_stall_i, mem_ack_i, mem_data_i[31:0]               (slave -> master)
//   - byte stream towards the UART/host uplink
//     tx_data_o[7:0], tx_valid_o                             (master -> slave)
//     tx_ready_i                                             (slave -> master)
//   Signal names keep their original direction suffixes, seen from the reader.
interface capture_reader_if;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_sel_o;
   logic        mem_we_o;
   logic        mem_stb_o;
   logic        mem_stall_i;
   logic        mem_ack_i;
   logic [31:0] mem_data_i;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i;

   modport master (
      output mem_addr_o, mem_sel_o, mem_we_o, mem_stb_o,
      input  mem_stall_i, mem_ack_i, mem_data_i,
      output tx_data_o, tx_valid_o,
      input  tx_ready_i
   );

   modport slave (
      input  mem_addr_o, mem_sel_o, mem_we_o, mem_stb_o,
      output mem_stall_i, mem_ack_i, mem_data_i,
      input  tx_data_o, tx_valid_o,
      output tx_ready_i
   );
endinterface

// File: rtl/capture_reader.sv
// capture_reader
//   Read-back engine for the sniffer sample RAM. Fetches a block of 32-bit
//   capture words over a Wishbone read-only port (one read outstanding at a
//   time) and serialises each word LSB first onto a valid/ready byte stream.
// Parameters
//   BASE_ADDR  byte address of word 0 of the capture buffer
//   BUF_WORDS  buffer depth in words (power of two); word index wraps
// Ports
//   clk_i         system clock
//   rst_n_i       asynchronous active-low reset
//   start_i       pulse: begin read-out (only honoured when idle)
//   start_word_i  first word index, taken modulo BUF_WORDS
//   len_i         number of words, 0 legal
//   abort_i       pulse: terminate read-out early
//   busy_o        read-out in progress (through the done cycle)
//   done_o        one-cycle completion/abort pulse
//   bus           capture_reader_if.master: Wishbone bus + byte stream
module capture_reader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned BUF_WORDS = 4096
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic [31:0] start_word_i,
   input  logic [15:0] len_i,
   input  logic        abort_i,
   output logic        busy_o,
   output logic        done_o,
   capture_reader_if.master bus
);

   localparam int unsigned IDX_W = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;

   typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx;
   logic [15:0]      rem;
   logic [31:0]      word;
   logic [1:0]       byte_idx;
   logic             abort_pend;
   logic             accept;
   logic             tx_fire;
   logic             last_byte;

   assign accept    = (state == REQ) && !bus.mem_stall_i;
   assign tx_fire   = (state == SHIFT) && bus.tx_ready_i;
   assign last_byte = tx_fire && (byte_idx == 2'd3);

   // state register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start_i) state_nxt = (len_i != '0) ? REQ : DONE;
         end
         REQ: begin
            // An abort in the accept cycle cannot cancel the read already on
            // the bus: go on to WAIT_ACK and let the pending flag end it there.
            if (!bus.mem_stall_i)  state_nxt = WAIT_ACK;
            else if (abort_i)      state_nxt = DONE;
         end
         WAIT_ACK: begin
            if (bus.mem_ack_i) state_nxt = (abort_i || abort_pend) ? DONE : SHIFT;
         end
         SHIFT: begin
            // final byte handshake wins over a coincident abort: byte delivered
            if (last_byte)    state_nxt = (rem == 16'd1 || abort_i) ? DONE : REQ;
            else if (abort_i) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // datapath registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         idx        <= '0;
         rem        <= '0;
         word       <= '0;
         byte_idx   <= '0;
         abort_pend <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               abort_pend <= 1'b0;
               if (start_i && len_i != '0) begin
                  idx <= IDX_W'(start_word_i % BUF_WORDS);
                  rem <= len_i;
               end
            end
            REQ: begin
               if (accept && abort_i) abort_pend <= 1'b1;
            end
            WAIT_ACK: begin
               if (abort_i) abort_pend <= 1'b1;
               if (bus.mem_ack_i) begin
                  word     <= bus.mem_data_i;
                  byte_idx <= '0;
               end
            end
            SHIFT: begin
               if (tx_fire) begin
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     rem <= rem - 16'd1;
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // outputs, decoded from state so an async reset clears them immediately
   always_comb begin
      busy_o         = (state != IDLE);
      done_o         = (state == DONE);
      bus.mem_stb_o  = (state == REQ);
      bus.mem_addr_o = BASE_ADDR + (32'(idx) << 2);
      bus.mem_sel_o  = 4'hF;
      bus.mem_we_o   = 1'b0;
      bus.tx_valid_o = (state == SHIFT);
      bus.tx_data_o  = '0;
      if (state == SHIFT) bus.tx_data_o = word[{byte_idx, 3'b000} +: 8];
   end

endmodule
